// File: rtl/spi_ip_req_arbiter.sv
// spi_ip_req_arbiter: round-robin sharing of one SPI master core's TX/RX buffers between requesters, with burst watchdog.
module spi_ip_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                            arb_clk_i,
  input  logic                            arb_rst_i,
  input  logic [NUM_REQ-1:0]              arb_req_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    arb_len_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   arb_tx_data_i,
  output logic [NUM_REQ-1:0]              arb_tx_ack_o,
  output logic [DATA_WIDTH-1:0]           arb_rx_data_o,
  output logic [NUM_REQ-1:0]              arb_rx_valid_o,
  output logic [NUM_REQ-1:0]              arb_done_o,
  output logic [NUM_REQ-1:0]              arb_err_o,
  output logic [NUM_REQ-1:0]              arb_grant_o,
  output logic                            arb_spi_en_o,
  input  logic                            arb_txe_flag_i,
  output logic                            arb_tx_wr_o,
  output logic [DATA_WIDTH-1:0]           arb_tx_data_o,
  input  logic                            arb_rxne_flag_i,
  output logic                            arb_rx_rd_o,
  input  logic [DATA_WIDTH-1:0]           arb_rx_data_i,
  input  logic                            arb_busy_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, GRANT, LOAD, WAIT_RX, DRAIN, RELEASE} state_t;
  state_t state;
  logic [IW-1:0] ptr, gidx, pick, idx;
  logic [LEN_WIDTH-1:0] cnt;
  logic [WW-1:0] wdog;
  logic [NUM_REQ-1:0] g_onehot;
  logic aborted, waiting, timeout;
  // circular scan: the lowest offset from ptr with a request wins
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (arb_req_i[idx]) pick = idx;
    end
  end
  // the watchdog abort takes priority over any flag seen in the same cycle
  always_comb begin
    g_onehot = NUM_REQ'(1) << gidx;
    waiting = state inside {LOAD, WAIT_RX, DRAIN};
    timeout = waiting && wdog == WW'(TIMEOUT - 1);
    arb_tx_wr_o = state == LOAD && arb_txe_flag_i && !timeout;
    arb_rx_rd_o = state == WAIT_RX && arb_rxne_flag_i && !timeout;
    arb_tx_data_o = arb_tx_wr_o ? arb_tx_data_i[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    arb_tx_ack_o = arb_tx_wr_o ? g_onehot : '0;
    arb_done_o = state == RELEASE ? g_onehot : '0;
    arb_err_o = state == RELEASE && aborted ? g_onehot : '0;
  end
  always_ff @(posedge arb_clk_i) begin
    if (arb_rst_i) begin
      state <= IDLE;
      ptr <= '0;
      gidx <= '0;
      cnt <= '0;
      wdog <= '0;
      aborted <= 1'b0;
      arb_grant_o <= '0;
      arb_spi_en_o <= 1'b0;
      arb_rx_data_o <= '0;
      arb_rx_valid_o <= '0;
    end else begin
      arb_rx_valid_o <= '0;
      wdog <= waiting ? wdog + 1'b1 : '0;
      if (timeout) begin
        state <= RELEASE;
        aborted <= 1'b1;
        arb_grant_o <= '0;
        arb_spi_en_o <= 1'b0;
        wdog <= '0;
      end else begin
        case (state)
          IDLE: if (|arb_req_i) begin
            gidx <= pick;
            arb_grant_o <= NUM_REQ'(1) << pick;
            arb_spi_en_o <= 1'b1;
            cnt <= arb_len_i[int'(pick)*LEN_WIDTH +: LEN_WIDTH];
            aborted <= 1'b0;
            state <= GRANT;
          end
          GRANT: state <= LOAD;
          LOAD: if (arb_txe_flag_i) begin
            state <= WAIT_RX;
            wdog <= '0;
          end
          WAIT_RX: if (arb_rxne_flag_i) begin
            arb_rx_data_o <= arb_rx_data_i;
            arb_rx_valid_o <= g_onehot;
            wdog <= '0;
            state <= cnt == '0 ? DRAIN : LOAD;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
          DRAIN: if (!arb_busy_i && !arb_rxne_flag_i) begin
            state <= RELEASE;
            arb_grant_o <= '0;
            arb_spi_en_o <= 1'b0;
            wdog <= '0;
          end
          RELEASE: begin
            ptr <= gidx == IW'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/spi_ip_req_arbiter.md
Name: spi_ip_req_arbiter

Overview:
Shares one SPI IP core, configured as master, between NUM_REQ requesters.
- Grants the core round-robin and holds the grant for a whole burst.
- Per frame: writes TX data into the core's TX buffer, then collects the received byte from the RX buffer.
- After the last frame, waits for the core to go idle, signals completion to the requester and re-arbitrates.
- Sits between client logic and the SPI IP's buffer/flag interface; a watchdog aborts stalled bursts.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, frame width
LEN_WIDTH, 4, burst length field width; burst = len+1 frames
TIMEOUT, 1023, max cycles waiting on any single SPI flag before abort

Ports:
arb_clk_i  in  1  clock
arb_rst_i  in  1  synchronous active-high reset
arb_req_i  in  NUM_REQ  level request per requester
arb_len_i  in  NUM_REQ*LEN_WIDTH  frames-1 per requester, slice k = requester k
arb_tx_data_i  in  NUM_REQ*DATA_WIDTH  next TX frame per requester
arb_tx_ack_o  out  NUM_REQ  1-cycle pulse: granted requester's TX frame consumed
arb_rx_data_o  out  DATA_WIDTH  captured RX frame
arb_rx_valid_o  out  NUM_REQ  1-cycle pulse: arb_rx_data_o valid for that requester
arb_done_o  out  NUM_REQ  1-cycle pulse: burst finished
arb_err_o  out  NUM_REQ  1-cycle pulse, together with done: burst aborted by timeout
arb_grant_o  out  NUM_REQ  one-hot current owner, 0 when idle
arb_spi_en_o  out  1  SPI core enable, high while a burst is granted
arb_txe_flag_i  in  1  1 = core TX buffer empty
arb_tx_wr_o  out  1  TX buffer write strobe
arb_tx_data_o  out  DATA_WIDTH  TX buffer write data
arb_rxne_flag_i  in  1  1 = core RX buffer holds a frame
arb_rx_rd_o  out  1  RX buffer read strobe, pops the frame
arb_rx_data_i  in  DATA_WIDTH  RX buffer head data
arb_busy_i  in  1  core busy

Behaviour:
- Reset: every output 0; state IDLE; round-robin pointer = 0; frame counter = 0; watchdog = 0. Reset asserted mid-burst abandons the burst; no done/err pulse is issued.
- States: IDLE, GRANT, LOAD, WAIT_RX, DRAIN, RELEASE.
- IDLE: if any arb_req_i bit is set, pick the first set bit at or after the pointer (circular scan). Register the one-hot grant, latch that requester's len into the frame counter, go to GRANT.
- GRANT: arb_spi_en_o=1 (stays 1 until RELEASE); go to LOAD.
- LOAD: wait for arb_txe_flag_i=1. In that cycle:
  - arb_tx_wr_o=1, arb_tx_data_o = granted requester's slice.
  - arb_tx_ack_o[g]=1, and the requester must present its next frame by the following cycle.
  - Go to WAIT_RX.
  - arb_tx_data_o is 0 whenever arb_tx_wr_o=0.
- WAIT_RX: wait for arb_rxne_flag_i=1. In that cycle arb_rx_rd_o=1 and arb_rx_data_i is captured into arb_rx_data_o. Next cycle arb_rx_valid_o[g]=1.
  - Counter 0: go to DRAIN.
  - Otherwise: decrement counter, return to LOAD.
- DRAIN: wait for arb_busy_i=0 and arb_rxne_flag_i=0, then go to RELEASE.
- RELEASE, one cycle:
  - arb_done_o[g]=1; arb_spi_en_o=0; arb_grant_o=0.
  - Pointer = g+1, wrapping from NUM_REQ-1 to 0.
  - Go to IDLE.
- Watchdog: counts cycles spent in LOAD, WAIT_RX or DRAIN; cleared on every state change. When it reaches TIMEOUT, go to RELEASE and pulse arb_err_o[g] together with arb_done_o[g]. No tx_wr/rx_rd is issued in the abort cycle.
- Grant latency: request seen in IDLE at cycle n → arb_grant_o valid at n+1 → arb_spi_en_o at n+1 → first possible tx_wr at n+2.
- Dropping a request mid-burst is ignored; the burst always completes or times out.
- Requests are not sampled during RELEASE, so there is at least one idle cycle between bursts.
- arb_len_i and the requester index are sampled only in IDLE.
- arb_txe_flag_i and arb_rxne_flag_i both high in LOAD: only the write occurs; the RX frame is handled in WAIT_RX.
- Outputs arb_grant_o, arb_spi_en_o and arb_rx_data_o are registered. Strobes are decoded from registered state plus the current flag input.

Test Plan:
- Single burst: req[0]=1, len=2, tx bytes 0xA1,0xA2,0xA3, core model echoes RX with 0x5x → 3 tx_wr with A1..A3, 3 rx_valid[0] with 0x51..0x53, one done[0], err=0, spi_en drops in RELEASE.
- Fairness: req=4'b1111 held, len=0 each → grant order 0,1,2,3,0; each grant produces exactly one tx_wr and one done.
- Wrap/skip: pointer=3, req=4'b0101 → grant requester 0, then 2; never 1 or 3.
- TX back-pressure: txe_flag held 0 for 50 cycles in LOAD → no tx_wr during the wait; write fires the cycle txe rises; no timeout.
- Timeout: rxne never asserted, TIMEOUT=1023 → done[g] and err[g] pulse after 1023 WAIT_RX cycles; grant released; next requester served.
- Reset mid-burst after 2 of 4 frames → next cycle all outputs 0, pointer 0, no done pulse; new request is granted normally afterwards.
